// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice per clock, LSB first, carry kept in a flip-flop.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.

module fulladder (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);
  assign s = x ^ y ^ z;
  assign c = (x & y) | (z & (x ^ y));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_next;
  logic [CW-1:0]    bit_cnt;
  logic             carry;
  logic             last_bit;
  logic             fa_s;
  logic             fa_c;

  fulladder u_fa (
    .x(a_sh[0]),
    .y(b_sh[0]),
    .z(carry),
    .s(fa_s),
    .c(fa_c)
  );

  assign last_bit = (bit_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Each new sum bit enters at the MSB so the LSB lands in bit 0 after WIDTH shifts.
  always_comb begin
    sum_next            = sum >> 1;
    sum_next[WIDTH-1]   = fa_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      carry   <= 1'b0;
      bit_cnt <= '0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            carry   <= cin;
            bit_cnt <= '0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          sum     <= sum_next;
          carry   <= fa_c;
          bit_cnt <= bit_cnt + CW'(1);
          if (last_bit) begin
            cout <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            // carry still holds the carry into the MSB on the last slice
            ovf  <= carry ^ fa_c;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
